// File: rtl/inst_encoder.sv
// RV32 instruction word assembler: packs decoded fields and a 32-bit immediate
// into one word, or expands LI into LUI/ADDI, behind a single registered output stage.
`ifndef TYPE_BUS
`define TYPE_BUS 2:0
`endif
`ifndef INST_R
`define INST_R 3'd0
`endif
`ifndef INST_I
`define INST_I 3'd1
`endif
`ifndef INST_S
`define INST_S 3'd2
`endif
`ifndef INST_B
`define INST_B 3'd3
`endif
`ifndef INST_U
`define INST_U 3'd4
`endif
`ifndef INST_J
`define INST_J 3'd5
`endif

module inst_encoder (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [`TYPE_BUS]  itype,
  input  logic              li,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm32,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst,
  output logic              err
);

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_LUI = 7'h37;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    LI_HI
  } state_t;

  state_t      state_q;
  logic        out_valid_q;
  logic [31:0] inst_q;
  logic        err_q;
  logic [31:0] pend_q;

  logic        accept;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic [19:0] li_hi;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        enc_two;
  logic [31:0] enc_pend;

  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    fits12 = (imm32[31:11] == '0) || (imm32[31:11] == '1);
    fits13 = (imm32[31:12] == '0) || (imm32[31:12] == '1);
    fits21 = (imm32[31:20] == '0) || (imm32[31:20] == '1);
    // (imm32 + 0x800) >> 12 reduces to the upper field plus the rounding carry from bit 11
    li_hi  = imm32[31:12] + {19'd0, imm32[11]};
  end

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    enc_pend = '0;
    if (li) begin
      if (fits12) begin
        enc_word = {imm32[11:0], 5'd0, 3'b000, rd, OP_IMM};
      end else begin
        enc_word = {li_hi, rd, OP_LUI};
        if (imm32[11:0] != '0) begin
          enc_two  = 1'b1;
          enc_pend = {imm32[11:0], rd, 3'b000, rd, OP_IMM};
        end
      end
    end else begin
      case (itype)
        `INST_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        `INST_I: begin
          enc_word = {imm32[11:0], rs1, funct3, rd, opcode};
          enc_err  = !fits12;
        end
        `INST_S: begin
          enc_word = {imm32[11:5], rs2, rs1, funct3, imm32[4:0], opcode};
          enc_err  = !fits12;
        end
        `INST_B: begin
          enc_word = {imm32[12], imm32[10:5], rs2, rs1, funct3, imm32[4:1], imm32[11], opcode};
          enc_err  = !fits13 || imm32[0];
        end
        `INST_U: begin
          enc_word = {imm32[31:12], rd, opcode};
          enc_err  = (imm32[11:0] != '0);
        end
        `INST_J: begin
          enc_word = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], rd, opcode};
          enc_err  = !fits21 || imm32[0];
        end
        default: begin
          enc_word = '0;
          enc_err  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      err_q       <= 1'b0;
      pend_q      <= '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            inst_q      <= enc_word;
            err_q       <= enc_err;
            out_valid_q <= 1'b1;
            pend_q      <= enc_pend;
            state_q     <= enc_two ? LI_HI : HOLD;
          end else if ((state_q == HOLD) && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        LI_HI: begin
          if (out_ready) begin
            inst_q  <= pend_q;
            err_q   <= 1'b0;
            pend_q  <= '0;
            state_q <= HOLD;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    inst      = inst_q;
    err       = err_q;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Assembles 32-bit RV32 instruction words from decoded fields and a 32-bit immediate. It is the inverse of the immediate extraction and sign-extension path in decode.
- Also expands the LI pseudo-op into a LUI/ADDI pair.
- Consumers are the self-test instruction generator and the difftest stimulus path.
- Valid/ready on input and output; one registered output stage; small FSM for two-word expansion.

Parameters:
- None. Type encoding comes from the `TYPE_BUS width and the `INST_R/I/S/B/U/J codes in defines.v.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- itype  in  `TYPE_BUS  instruction format code (`INST_*)
- li  in  1  LI pseudo-op; overrides itype, opcode, rs1, rs2, funct3, funct7
- opcode  in  7  bits [6:0] of the output word
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  function field
- funct7  in  7  R-type funct7
- imm32  in  32  full-width signed immediate/offset (B/J: byte offset; U: value already shifted left 12)
- out_valid  out  1  inst valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- inst  out  32  encoded instruction
- err  out  1  qualifies inst: immediate not representable, or unknown itype

Behaviour:
- Reset: state=IDLE; out_valid=0, inst=0, err=0, pending word cleared. Reset overrides any in-flight handshake, including mid-LI; the second LI word is discarded.
- States:
  - IDLE: no output held.
  - HOLD: one word valid at output.
  - LI_HI: LUI valid at output, ADDI pending.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is 0 in LI_HI. Throughput is one word per cycle when out_ready=1.
- Latency: the word appears on inst/out_valid the cycle after acceptance.
- While out_valid && !out_ready, inst and err hold stable.
- Transitions:
  - IDLE/HOLD on accept goes to HOLD, or to LI_HI for a two-word LI.
  - HOLD with out_ready and no accept goes to IDLE.
  - LI_HI with out_ready loads the pending ADDI and goes to HOLD.
- Encoding (fields concatenated MSB to LSB):
  - R: funct7, rs2, rs1, funct3, rd, opcode. err=0. imm32 ignored.
  - I: imm[11:0], rs1, funct3, rd, opcode. err if imm32 not in [-2048,2047].
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode. Same range rule as I.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode. err if imm32 not in [-4096,4094] or imm[0]=1.
  - U: imm[31:12], rd, opcode. err if imm[11:0]!=0.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode. err if imm32 not in [-2^20, 2^20-2] or imm[0]=1.
  - Unknown itype: inst=32'h0, err=1.
  - On err, the word is still encoded from the truncated bits as above.
- LI (li=1; rd and imm32 used; err always 0):
  - lo = imm32[11:0] as signed; hi = (imm32 + 32'h800) >> 12, wrapping mod 2^32.
  - imm32 in [-2048,2047]: single ADDI rd,x0,lo (opcode 0x13, funct3 0).
  - else if lo==0: single LUI rd,hi (opcode 0x37).
  - else: LUI rd,hi, then ADDI rd,rd,lo as two beats, in order.
- Round-trip property: for err=0 and non-LI, decoding inst through imm_extend returns imm32.

Test Plan:
- I-type: opcode 0x13, rd=1, rs1=0, funct3=0, imm32=-1 -> inst 0xFFF00093, err=0, out_valid one cycle after accept.
- B-type: opcode 0x63, rs1=1, rs2=2, funct3=0, imm32=-4 -> 0xFE208EE3, err=0. Same with imm32=-3 -> err=1.
- LI rd=5, imm32=0x12345FFF -> two beats 0x123462B7 then 0xFFF28293; in_ready=0 between them. LI imm32=0x00001000 -> single 0x000012B7.
- Range errors: I-type imm32=2048 -> err=1, imm field 0x800. U-type imm32=0x00001001 -> err=1. Unknown itype -> inst 0, err=1.
- Backpressure and reset:
  - out_ready=0 for 3 cycles -> inst/err stable, in_ready=0.
  - rst during LI_HI -> out_valid=0 next cycle and no ADDI emitted.
- Throughput: out_ready=1 and 4 back-to-back R-type requests -> 4 words on consecutive cycles, in order, in_ready held at 1.
